// File: rtl/updi_target_phy.sv
// updi_target_phy: target-side UPDI PHY, half-duplex 12-bit frame receiver and transmitter
module updi_target_phy #(
    parameter int CLKS_PER_BIT = 4,
    parameter int GUARD_BITS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic       tx_line,
    output logic       tx_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       break_det,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int GW = $clog2((GUARD_BITS + 1) * CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] R_HALF = CW'(HALF > 0 ? HALF - 1 : 0);
    localparam logic [CW-1:0] R_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] T_BIT = GW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] T_GLOAD = GW'(GUARD_BITS > 0 ? GUARD_BITS * CLKS_PER_BIT - 1 : 0);
    localparam logic [1:0] R_IDLE = 2'd0, R_START = 2'd1, R_BITS = 2'd2, R_BREAK = 2'd3;
    localparam logic [1:0] T_IDLE = 2'd0, T_GUARD = 2'd1, T_SHIFT = 2'd2;

    logic          s1_q, s2_q;
    logic [1:0]    r_q, r_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [3:0]    rbit_q, rbit_d;
    logic [9:0]    rsh_q, rsh_d;
    logic [10:0]   frame;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
    logic [1:0]    t_q, t_d;
    logic [GW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    tbit_q, tbit_d;
    logic [11:0]   tsh_q, tsh_d;
    logic          done_q, done_d;

    // k=11 sample joined with the ten earlier samples; bit 0 is d0
    assign frame = {s2_q, rsh_q};

    assign tx_ready      = !rst && t_q == T_IDLE && r_q == R_IDLE && s2_q;
    assign tx_oe         = t_q == T_SHIFT;
    assign tx_line       = t_q == T_SHIFT ? tsh_q[0] : 1'b1;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign break_det     = brk_q;
    assign tx_done       = done_q;

    // Receive FSM: mid-bit sampling, held idle while the transmitter owns the wire
    always_comb begin
        r_d        = r_q;
        rcnt_d     = rcnt_q - 1'b1;
        rbit_d     = rbit_q;
        rsh_d      = rsh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = 1'b0;
        case (r_q)
            R_IDLE: if (!s2_q && t_q == T_IDLE) begin
                r_d    = HALF == 0 ? R_BITS : R_START;
                rcnt_d = HALF == 0 ? R_BIT : R_HALF;
                rbit_d = 4'd1;
            end
            R_START: if (rcnt_q == '0) begin
                r_d    = s2_q ? R_IDLE : R_BITS;
                rcnt_d = R_BIT;
                rbit_d = 4'd1;
            end
            R_BITS: if (rcnt_q == '0) begin
                rsh_d  = frame[10:1];
                rcnt_d = R_BIT;
                rbit_d = rbit_q + 4'd1;
                if (rbit_q == 4'd11) begin
                    r_d = frame == '0 ? R_BREAK : R_IDLE;
                    if (frame != '0) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = frame[7:0];
                        perr_d     = ^frame[8:0];
                        ferr_d     = !(frame[9] && frame[10]);
                    end
                end
            end
            R_BREAK: if (s2_q) begin
                r_d   = R_IDLE;
                brk_d = 1'b1;
            end
            default: r_d = R_IDLE;
        endcase
    end

    // Transmit FSM: guard time, then start, data LSB-first, even parity, two stops
    always_comb begin
        t_d    = t_q;
        tcnt_d = tcnt_q - 1'b1;
        tbit_d = tbit_q;
        tsh_d  = tsh_q;
        done_d = 1'b0;
        case (t_q)
            T_IDLE: if (tx_valid && tx_ready) begin
                tsh_d  = {2'b11, ^tx_data, tx_data, 1'b0};
                t_d    = GUARD_BITS == 0 ? T_SHIFT : T_GUARD;
                tcnt_d = GUARD_BITS == 0 ? T_BIT : T_GLOAD;
                tbit_d = 4'd0;
            end
            T_GUARD: if (tcnt_q == '0) begin
                t_d    = T_SHIFT;
                tcnt_d = T_BIT;
            end
            T_SHIFT: if (tcnt_q == '0) begin
                tcnt_d = T_BIT;
                tsh_d  = {1'b1, tsh_q[11:1]};
                tbit_d = tbit_q + 4'd1;
                t_d    = tbit_q == 4'd11 ? T_IDLE : T_SHIFT;
                done_d = tbit_q == 4'd11;
            end
            default: t_d = T_IDLE;
        endcase
    end

    // State registers and line synchronizer; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            r_q        <= R_IDLE;
            rcnt_q     <= '0;
            rbit_q     <= '0;
            rsh_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
            t_q        <= T_IDLE;
            tcnt_q     <= '0;
            tbit_q     <= '0;
            tsh_q      <= '1;
            done_q     <= 1'b0;
        end else begin
            s1_q       <= rx_line;
            s2_q       <= s1_q;
            r_q        <= r_d;
            rcnt_q     <= rcnt_d;
            rbit_q     <= rbit_d;
            rsh_q      <= rsh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
            t_q        <= t_d;
            tcnt_q     <= tcnt_d;
            tbit_q     <= tbit_d;
            tsh_q      <= tsh_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_updi_target_phy.sv
// tb_updi_target_phy: directed checks of the UPDI target PHY at 4 clocks per bit, 2 guard bits
module tb_updi_target_phy;
    logic       clk = 1'b0, rst = 1'b1, rx_line = 1'b1, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_line, tx_oe, rx_valid, rx_parity_err, rx_frame_err, break_det, tx_ready, tx_done;
    logic [7:0] rx_data;
    int vec = 0, errs = 0;

    updi_target_phy #(.CLKS_PER_BIT(4), .GUARD_BITS(2)) dut (
        .clk(clk), .rst(rst), .rx_line(rx_line), .tx_line(tx_line), .tx_oe(tx_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .break_det(break_det), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_line = 1'b1; tx_valid = 1'b0;
        repeat (3) tick();
        vec++;
        if ({tx_line, tx_oe, tx_ready, tx_done} !== 4'b1000) begin
            errs++; $display("FAIL reset_tx: line/oe/ready/done got %b want 1000", {tx_line, tx_oe, tx_ready, tx_done});
        end
        vec++;
        if ({rx_valid, rx_parity_err, rx_frame_err, break_det} !== 4'b0000) begin
            errs++; $display("FAIL reset_rx: valid/perr/ferr/brk got %b want 0000", {rx_valid, rx_parity_err, rx_frame_err, break_det});
        end
        vec++;
        if (rx_data !== 8'h00) begin
            errs++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        rst = 1'b0;
        tick();
        vec++;
        if (tx_ready !== 1'b1) begin
            errs++; $display("FAIL ready_after_reset: got %b want 1", tx_ready);
        end
    endtask

    task automatic test_rx_frame(input logic [11:0] f, input logic [7:0] ed, input logic ep, input logic ef, input string nm);
        int nv = 0, nb = 0;
        logic [7:0] d = 8'hxx;
        logic pe = 1'bx, fe = 1'bx;
        for (int i = 0; i < 78; i++) begin
            rx_line = i < 48 ? f[i/4] : 1'b1;
            tick();
            if (rx_valid) begin
                nv++; d = rx_data; pe = rx_parity_err; fe = rx_frame_err;
            end
            if (break_det) nb++;
        end
        vec++;
        if (nv != 1) begin errs++; $display("FAIL %s_count: rx_valid pulses %0d want 1", nm, nv); end
        vec++;
        if (d !== ed) begin errs++; $display("FAIL %s_data: got %h want %h", nm, d, ed); end
        vec++;
        if ({pe, fe} !== {ep, ef}) begin errs++; $display("FAIL %s_flags: perr/ferr got %b%b want %b%b", nm, pe, fe, ep, ef); end
        vec++;
        if (nb != 0 || rx_data !== ed) begin errs++; $display("FAIL %s_hold: breaks %0d rx_data %h want 0 %h", nm, nb, rx_data, ed); end
    endtask

    task automatic test_break;
        int nv = 0, nb = 0;
        logic [5:0] b;
        rx_line = 1'b0;
        for (int i = 0; i < 56; i++) begin
            tick();
            if (rx_valid) nv++;
            if (break_det) nb++;
        end
        rx_line = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            b[i] = break_det;
            if (rx_valid) nv++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rx_valid) nv++;
            if (break_det) nb++;
        end
        vec++;
        if (b !== 6'b000100 || nb != 0) begin
            errs++; $display("FAIL break_pulse: post-rise pattern %b extra %0d want 000100 0", b, nb);
        end
        vec++;
        if (nv != 0) begin errs++; $display("FAIL break_no_valid: rx_valid pulses %0d want 0", nv); end
    endtask

    task automatic test_glitch;
        int n = 0;
        rx_line = 1'b0;
        tick();
        rx_line = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rx_valid || break_det) n++;
        end
        vec++;
        if (n != 0 || rx_data !== 8'hA5) begin
            errs++; $display("FAIL glitch: pulses %0d rx_data %h want 0 a5", n, rx_data);
        end
    endtask

    task automatic test_tx;
        int gbad = 0, nv = 0, nd = 0;
        logic [11:0] exp_f = 12'hE38;
        tx_data = 8'h1C; tx_valid = 1'b1;
        vec++;
        if (tx_ready !== 1'b1) begin errs++; $display("FAIL tx_accept_ready: got %b want 1", tx_ready); end
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (tx_oe !== 1'b0 || tx_line !== 1'b1) gbad++;
            if (rx_valid) nv++;
            tick();
        end
        vec++;
        if (gbad != 0) begin errs++; $display("FAIL tx_guard: %0d bad cycles want 0", gbad); end
        for (int b = 0; b < 12; b++) begin
            int bad = 0;
            for (int c = 0; c < 4; c++) begin
                if (tx_oe !== 1'b1 || tx_line !== exp_f[b]) bad++;
                if (tx_done) nd++;
                if (rx_valid) nv++;
                rx_line = tx_line;
                tick();
            end
            vec++;
            if (bad != 0) begin errs++; $display("FAIL tx_bit%0d: %0d bad cycles, want oe=1 line=%b", b, bad, exp_f[b]); end
        end
        rx_line = 1'b1;
        vec++;
        if ({tx_done, tx_oe, tx_line} !== 3'b101 || nd != 0) begin
            errs++; $display("FAIL tx_done: done/oe/line %b early %0d want 101 0", {tx_done, tx_oe, tx_line}, nd);
        end
        tick();
        vec++;
        if (tx_done !== 1'b0) begin errs++; $display("FAIL tx_done_pulse: got %b want 0", tx_done); end
        for (int i = 0; i < 10; i++) begin
            if (rx_valid) nv++;
            tick();
        end
        vec++;
        if (nv != 0) begin errs++; $display("FAIL tx_echo_ignored: rx_valid pulses %0d want 0", nv); end
    endtask

    task automatic test_rst_mid;
        int nd = 0, no = 0;
        tx_data = 8'h00; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (18) tick();
        vec++;
        if ({tx_oe, tx_line} !== 2'b10) begin errs++; $display("FAIL rst_mid_pre: oe/line %b want 10", {tx_oe, tx_line}); end
        rst = 1'b1;
        tick();
        vec++;
        if ({tx_oe, tx_line} !== 2'b01) begin errs++; $display("FAIL rst_mid: oe/line %b want 01", {tx_oe, tx_line}); end
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (tx_done) nd++;
            if (tx_oe) no++;
        end
        vec++;
        if (nd != 0 || no != 0) begin errs++; $display("FAIL rst_mid_after: done %0d oe %0d want 0 0", nd, no); end
    endtask

    task automatic test_collision;
        logic [11:0] f = {2'b11, 1'b0, 8'h3A, 1'b0};
        logic [11:0] exp_t = 12'hD86;
        logic [11:0] got = 12'h000;
        logic [7:0] d = 8'hxx;
        int nv = 0, noe = 0, oe_rx = 0, acc = 0, nd = 0;
        tx_data = 8'hC3;
        for (int i = 0; i < 48; i++) begin
            rx_line = f[i/4];
            if (i == 2) begin
                tx_valid = 1'b1;
                vec++;
                if (tx_ready !== 1'b0) begin errs++; $display("FAIL collide_ready: got %b want 0", tx_ready); end
            end
            if (tx_valid && tx_ready) acc++;
            tick();
            if (tx_oe) oe_rx++;
            if (rx_valid) begin nv++; d = rx_data; end
        end
        rx_line = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic a = tx_valid && tx_ready;
            if (a) acc++;
            tick();
            if (a) tx_valid = 1'b0;
            if (rx_valid) begin nv++; d = rx_data; end
            if (tx_done) nd++;
            if (tx_oe) begin
                if (noe % 4 == 1) got[noe/4] = tx_line;
                noe++;
            end
        end
        tx_valid = 1'b0;
        vec++;
        if (oe_rx != 0) begin errs++; $display("FAIL collide_rx_first: tx_oe cycles during rx %0d want 0", oe_rx); end
        vec++;
        if (nv != 1 || d !== 8'h3A) begin errs++; $display("FAIL collide_rx: pulses %0d data %h want 1 3a", nv, d); end
        vec++;
        if (acc != 1 || nd != 1 || noe != 48) begin
            errs++; $display("FAIL collide_tx: accepts %0d done %0d oe %0d want 1 1 48", acc, nd, noe);
        end
        vec++;
        if (got !== exp_t) begin errs++; $display("FAIL collide_tx_bits: got %h want %h", got, exp_t); end
    endtask

    initial begin
        test_reset();
        test_rx_frame({2'b11, 1'b0, 8'h55, 1'b0}, 8'h55, 1'b0, 1'b0, "rx55");
        test_rx_frame({2'b11, 1'b0, 8'h07, 1'b0}, 8'h07, 1'b1, 1'b0, "rx07_par");
        test_rx_frame({2'b01, 1'b0, 8'hA5, 1'b0}, 8'hA5, 1'b0, 1'b1, "rxA5_stop");
        test_break();
        test_glitch();
        test_tx();
        test_rst_mid();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
